// File: rtl/mm_read_arbiter.sv
// rtl/mm_read_arbiter.sv - round-robin arbiter sharing one Avalon-MM read port between NUM_REQ masters
module mm_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0]     m_address,
  input  logic [NUM_REQ-1:0]            m_read,
  output logic [NUM_REQ-1:0]            m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_REQ-1:0]            m_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic [$clog2(MAX_OUT):0]      outstanding,
  output logic                          err_orphan
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUT);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick;
  logic [ADDR_W-1:0] sel_addr;
  logic            accept;

  // ID FIFO: one tag per accepted read, popped in order by returning beats
  logic [GW-1:0]   fifo_mem [MAX_OUT];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic [GW-1:0]   fifo_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count == '0);
  // A return in this cycle frees a slot, so a full FIFO still accepts a push alongside the pop
  assign fifo_full  = (count == FULL_CNT) & ~s_readdatavalid;
  assign pop        = s_readdatavalid & ~fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr];
  assign outstanding = count;

  // Circular search for the first requester at or after rr_ptr
  always_comb begin
    logic [GW-1:0] idx;
    pick = rr_ptr;
    idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (m_read[idx]) pick = idx;
    end
  end

  // Address mux for the granted master; unregistered, master holds it under waitrequest
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == GW'(k)) sel_addr = m_address[k*ADDR_W +: ADDR_W];
    end
  end

  // Slave-side request and per-master waitrequest, only the granted master can proceed
  always_comb begin
    s_read        = 1'b0;
    s_address     = '0;
    m_waitrequest = '1;
    if (state == GRANT) begin
      s_read               = m_read[grant] & ~fifo_full;
      s_address            = sel_addr;
      m_waitrequest[grant] = s_waitrequest | fifo_full;
    end
  end

  assign accept = s_read & ~s_waitrequest;

  // Steer returning beats to the master whose tag is at the FIFO head
  always_comb begin
    m_readdatavalid = '0;
    if (pop) m_readdatavalid[fifo_head] = 1'b1;
  end

  assign m_readdata = s_readdata;

  // Arbitration FSM: latch a grant in IDLE, hold it through stalls in GRANT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_read) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end else if (!m_read[grant]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO tag storage
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= grant;
  end

  // Sticky flag for a return beat with no tagged read behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan <= 1'b0;
    end else if (s_readdatavalid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mm_read_arbiter.sv
// tb/tb_mm_read_arbiter.sv - directed self-checking bench for mm_read_arbiter
module tb_mm_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [63:0] m_address;
  logic [1:0]  m_read;
  logic [1:0]  m_waitrequest;
  logic [63:0] m_readdata;
  logic [1:0]  m_readdatavalid;
  logic [31:0] s_address;
  logic        s_read;
  logic        s_waitrequest;
  logic [63:0] s_readdata;
  logic        s_readdatavalid;
  logic [2:0]  outstanding;
  logic        err_orphan;

  int errors = 0;
  int checks = 0;

  mm_read_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(64), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_read(m_read),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_read = 2'b00;
    s_waitrequest = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  logic [1:0]  exp_wr  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [31:0] exp_adr [4] = '{32'h1000, 32'h2000, 32'h1000, 32'h2000};
  logic [1:0]  exp_vld [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    logic        pend;
    logic [63:0] pend_data;
    int          ai;
    int          ri;

    rst_n = 1'b0;
    m_address = '0;
    m_read = '0;
    s_waitrequest = 1'b0;
    s_readdata = '0;
    s_readdatavalid = 1'b0;
    tick(2);

    // Reset values
    check("rst_m_wait", m_waitrequest, 2'b11);
    check("rst_m_vld", m_readdatavalid, 2'b00);
    check("rst_s_read", s_read, 1'b0);
    check("rst_s_addr", s_address, 32'h0);
    check("rst_outst", outstanding, 3'd0);
    check("rst_orphan", err_orphan, 1'b0);

    // Single read by master0
    do_reset();
    m_address = 64'h0;
    m_read = 2'b01;
    #1;
    check("single_idle_s_read", s_read, 1'b0);
    check("single_idle_wait", m_waitrequest, 2'b11);
    tick();
    check("single_grant_s_read", s_read, 1'b1);
    check("single_grant_addr", s_address, 32'h0);
    check("single_grant_wait", m_waitrequest, 2'b10);
    check("single_outst0", outstanding, 3'd0);
    tick();
    m_read = 2'b00;
    check("single_outst1", outstanding, 3'd1);
    check("single_idle2_s_read", s_read, 1'b0);
    s_readdatavalid = 1'b1;
    s_readdata = 64'h1122334455667788;
    #1;
    check("single_ret_vld", m_readdatavalid, 2'b01);
    check("single_ret_data", m_readdata, 64'h1122334455667788);
    tick();
    s_readdatavalid = 1'b0;
    check("single_outst_back0", outstanding, 3'd0);
    check("single_no_orphan", err_orphan, 1'b0);

    // Contention: both masters request, memory answers the cycle after accept
    do_reset();
    m_address = {32'h2000, 32'h1000};
    m_read = 2'b11;
    pend = 1'b0;
    pend_data = '0;
    ai = 0;
    ri = 0;
    for (int c = 0; c < 9; c++) begin
      s_readdatavalid = pend;
      s_readdata = pend_data;
      #1;
      if (pend && ri < 4) begin
        check("cont_ret_vld", m_readdatavalid, exp_vld[ri]);
        check("cont_ret_data", m_readdata, {32'hA5A5A5A5, exp_adr[ri]});
        ri++;
      end
      pend = 1'b0;
      if (s_read && !s_waitrequest && ai < 4) begin
        check("cont_grant", m_waitrequest, exp_wr[ai]);
        check("cont_addr", s_address, exp_adr[ai]);
        pend = 1'b1;
        pend_data = {32'hA5A5A5A5, s_address};
        ai++;
      end
      tick();
    end
    check("cont_accepts", ai, 4);
    check("cont_returns", ri, 4);
    s_readdatavalid = 1'b0;
    m_read = 2'b00;

    // Stall: master1 held under waitrequest for 5 cycles
    do_reset();
    m_address = {32'h3000, 32'h0};
    m_read = 2'b10;
    s_waitrequest = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("stall_wait", m_waitrequest, 2'b11);
      check("stall_addr", s_address, 32'h3000);
      check("stall_s_read", s_read, 1'b1);
      check("stall_outst", outstanding, 3'd0);
      tick();
    end
    s_waitrequest = 1'b0;
    #1;
    check("stall_release_wait", m_waitrequest, 2'b01);
    tick();
    m_read = 2'b00;
    check("stall_push", outstanding, 3'd1);
    tick();
    check("stall_single_push", outstanding, 3'd1);
    s_readdatavalid = 1'b1;
    #1;
    check("stall_ret_vld", m_readdatavalid, 2'b10);
    tick();
    s_readdatavalid = 1'b0;
    check("stall_drain", outstanding, 3'd0);

    // Full: four accepts with no returns, fifth waits for the first return
    do_reset();
    m_address = {32'h0, 32'h40};
    m_read = 2'b01;
    tick(9);
    check("full_outst", outstanding, 3'd4);
    check("full_s_read", s_read, 1'b0);
    check("full_wait", m_waitrequest, 2'b11);
    tick(2);
    check("full_hold_outst", outstanding, 3'd4);
    check("full_hold_s_read", s_read, 1'b0);
    s_readdatavalid = 1'b1;
    #1;
    check("full_pop_s_read", s_read, 1'b1);
    check("full_pop_wait", m_waitrequest, 2'b10);
    check("full_pop_vld", m_readdatavalid, 2'b01);
    tick();
    s_readdatavalid = 1'b0;
    m_read = 2'b00;
    check("full_pushpop_outst", outstanding, 3'd4);
    check("full_after_s_read", s_read, 1'b0);

    // Orphan return
    do_reset();
    s_readdatavalid = 1'b1;
    #1;
    check("orphan_vld", m_readdatavalid, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    check("orphan_set", err_orphan, 1'b1);
    tick(3);
    check("orphan_sticky", err_orphan, 1'b1);
    check("orphan_outst", outstanding, 3'd0);

    // Reset asserted mid-operation with three reads in flight
    do_reset();
    m_address = {32'h90, 32'h80};
    m_read = 2'b01;
    tick(7);
    check("midrst_pre_outst", outstanding, 3'd3);
    check("midrst_pre_s_read", s_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outst", outstanding, 3'd0);
    check("midrst_s_read", s_read, 1'b0);
    check("midrst_wait", m_waitrequest, 2'b11);
    check("midrst_addr", s_address, 32'h0);
    check("midrst_orphan", err_orphan, 1'b0);
    rst_n = 1'b1;
    m_read = 2'b11;
    tick();
    check("postrst_grant0", m_waitrequest, 2'b10);
    check("postrst_addr", s_address, 32'h80);
    tick();
    m_read = 2'b00;
    check("postrst_outst", outstanding, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
